// File: rtl/fc_layer_tiled.sv
// Tiled FC layer: buffers one input vector, then computes NUM_NEURONS outputs NUM_PE lanes at a time (FC_TILED_RELU_EN clamps negatives to 0).
// Latency: INPUT_SIZE+1 cycles per group after the last input accept, then one result per accepted handshake.
// Backpressure: out_ready low holds EMIT outputs stable; in_ready stays low until the final neuron is taken.
module fc_layer_tiled #(
  parameter int NUM_NEURONS  = 10,
  parameter int INPUT_SIZE   = 16,
  parameter int NUM_PE       = 4,
  parameter int DATA_WIDTH   = 16,
  parameter int WEIGHT_WIDTH = 8,
  parameter int ACC_WIDTH    = 32,
  parameter int FRAC_BITS    = 8,
  parameter int OUT_WIDTH    = 16,
  localparam int NUM_GROUPS  = (NUM_NEURONS + NUM_PE - 1) / NUM_PE,
  localparam int WA_W = (NUM_GROUPS * INPUT_SIZE > 1) ? $clog2(NUM_GROUPS * INPUT_SIZE) : 1,
  localparam int BA_W = (NUM_GROUPS > 1) ? $clog2(NUM_GROUPS) : 1,
  localparam int OI_W = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [DATA_WIDTH-1:0]          in_data,
  output logic [WA_W-1:0]                weight_addr,
  input  logic [NUM_PE*WEIGHT_WIDTH-1:0] weight_row,
  output logic [BA_W-1:0]                bias_addr,
  input  logic [NUM_PE*ACC_WIDTH-1:0]    bias_row,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [OUT_WIDTH-1:0]           out_data,
  output logic [OI_W-1:0]                out_index,
  output logic                           out_last,
  output logic                           busy
);

  localparam int CNT_W  = (INPUT_SIZE > 1) ? $clog2(INPUT_SIZE) : 1;
  localparam int K_W    = $clog2(INPUT_SIZE + 1);
  localparam int E_W    = (NUM_PE > 1) ? $clog2(NUM_PE) : 1;
  localparam int PROD_W = DATA_WIDTH + WEIGHT_WIDTH;
  localparam int LAST_L = NUM_NEURONS - (NUM_GROUPS - 1) * NUM_PE;
  localparam int SAT_MAX_I = (1 << (OUT_WIDTH - 1)) - 1;
  localparam logic signed [ACC_WIDTH-1:0] SAT_MAX = ACC_WIDTH'(SAT_MAX_I);
  localparam logic signed [ACC_WIDTH-1:0] SAT_MIN = ACC_WIDTH'(-SAT_MAX_I - 1);

  localparam logic [1:0] S_LOAD    = 2'd0;
  localparam logic [1:0] S_COMPUTE = 2'd1;
  localparam logic [1:0] S_EMIT    = 2'd2;

  logic [1:0]                   state;
  logic [CNT_W-1:0]             cnt;
  logic [K_W-1:0]               k;
  logic [BA_W-1:0]              g;
  logic [E_W-1:0]               e;
  logic signed [DATA_WIDTH-1:0] buf_mem [INPUT_SIZE];
  logic signed [DATA_WIDTH-1:0] x_reg;
  logic signed [ACC_WIDTH-1:0]  acc [NUM_PE];
  logic signed [ACC_WIDTH-1:0]  term [NUM_PE];
  logic signed [ACC_WIDTH-1:0]  bias_lane [NUM_PE];
  logic [CNT_W-1:0]             k_addr;
  logic                         last_k, last_g, last_e;
  logic signed [ACC_WIDTH-1:0]  shifted;
  logic signed [OUT_WIDTH-1:0]  sat_val;

  function automatic logic signed [ACC_WIDTH-1:0] mac_term(
    input logic signed [DATA_WIDTH-1:0] x,
    input logic [WEIGHT_WIDTH-1:0]      w
  );
    logic signed [PROD_W-1:0] p;
    p = PROD_W'(x) * PROD_W'($signed(w));
    return {{(ACC_WIDTH - PROD_W){p[PROD_W-1]}}, p};
  endfunction

  // Address stays on the last element during the final accumulate cycle
  assign k_addr = (k >= K_W'(INPUT_SIZE)) ? CNT_W'(INPUT_SIZE - 1) : k[CNT_W-1:0];
  assign last_k = (k == K_W'(INPUT_SIZE));
  assign last_g = (g == BA_W'(NUM_GROUPS - 1));
  assign last_e = (e == (last_g ? E_W'(LAST_L - 1) : E_W'(NUM_PE - 1)));

  assign weight_addr = WA_W'(g) * WA_W'(INPUT_SIZE) + WA_W'(k_addr);
  assign bias_addr   = g;
  assign in_ready    = (state == S_LOAD);
  assign busy        = (state != S_LOAD);
  assign out_valid   = (state == S_EMIT);
  assign out_index   = OI_W'(g) * OI_W'(NUM_PE) + OI_W'(e);
  assign out_last    = out_valid && (out_index == OI_W'(NUM_NEURONS - 1));

  always_comb begin
    for (int p = 0; p < NUM_PE; p++) begin
      term[p]      = mac_term(x_reg, weight_row[p*WEIGHT_WIDTH +: WEIGHT_WIDTH]);
      bias_lane[p] = bias_row[p*ACC_WIDTH +: ACC_WIDTH];
    end
  end

  always_comb begin
    shifted = acc[e] >>> FRAC_BITS;
    if (shifted > SAT_MAX) begin
      sat_val = {1'b0, {(OUT_WIDTH - 1){1'b1}}};
    end else if (shifted < SAT_MIN) begin
      sat_val = {1'b1, {(OUT_WIDTH - 1){1'b0}}};
    end else begin
      sat_val = shifted[OUT_WIDTH-1:0];
    end
    out_data = sat_val;
`ifdef FC_TILED_RELU_EN
    if (sat_val[OUT_WIDTH-1]) out_data = '0;
`endif
  end

  // Vector buffer survives reset on purpose; only the counters are cleared
  always_ff @(posedge clk) begin
    if (state == S_LOAD && in_valid) buf_mem[cnt] <= in_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_LOAD;
      cnt   <= '0;
      k     <= '0;
      g     <= '0;
      e     <= '0;
      x_reg <= '0;
      for (int p = 0; p < NUM_PE; p++) acc[p] <= '0;
    end else begin
      case (state)
        S_LOAD: begin
          if (in_valid) begin
            if (cnt == CNT_W'(INPUT_SIZE - 1)) begin
              cnt   <= '0;
              k     <= '0;
              g     <= '0;
              state <= S_COMPUTE;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
        end
        S_COMPUTE: begin
          x_reg <= buf_mem[k_addr];
          // ROM data and x_reg trail the address by one cycle
          for (int p = 0; p < NUM_PE; p++) begin
            if (k == K_W'(1))    acc[p] <= bias_lane[p] + term[p];
            else if (k != '0)    acc[p] <= acc[p] + term[p];
          end
          if (last_k) begin
            e     <= '0;
            state <= S_EMIT;
          end else begin
            k <= k + K_W'(1);
          end
        end
        S_EMIT: begin
          if (out_ready) begin
            if (last_e) begin
              e <= '0;
              k <= '0;
              if (last_g) begin
                g     <= '0;
                state <= S_LOAD;
              end else begin
                g     <= g + BA_W'(1);
                state <= S_COMPUTE;
              end
            end else begin
              e <= e + E_W'(1);
            end
          end
        end
        default: state <= S_LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_fc_layer_tiled.sv
// Scoreboard bench for fc_layer_tiled: expected results queued per vector, a monitor pops on each output handshake.
module tb_fc_layer_tiled;
  localparam int NN = 10;
  localparam int IS = 16;
  localparam int NP = 4;

  logic               clk = 1'b0;
  logic               rst;
  logic               in_valid, in_ready;
  logic [15:0]        in_data;
  logic [5:0]         weight_addr;
  logic [NP*8-1:0]    weight_row;
  logic [1:0]         bias_addr;
  logic [NP*32-1:0]   bias_row;
  logic               out_valid, out_ready;
  logic signed [15:0] out_data;
  logic [3:0]         out_index;
  logic               out_last, busy;

  fc_layer_tiled dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .weight_addr(weight_addr), .weight_row(weight_row),
    .bias_addr(bias_addr), .bias_row(bias_row),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_index(out_index), .out_last(out_last), .busy(busy)
  );

  always #5 clk = ~clk;

  logic [NP*8-1:0]  wrom [64];
  logic [NP*32-1:0] brom [4];
  always @(posedge clk) begin
    weight_row <= wrom[weight_addr];
    bias_row   <= brom[bias_addr];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int data; int idx; int last; } exp_t;
  exp_t sb_q[$];

  int tests = 0;
  int fails = 0;
  int t0 = 0;
  int first_valid = -1;
  int last_hs = -1;
  int ac;
  bit addr_chk_en = 1'b0;

  task automatic check(input string name, input logic signed [31:0] act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int relu(input int v);
`ifdef FC_TILED_RELU_EN
    return (v < 0) ? 0 : v;
`else
    return v;
`endif
  endfunction

  task automatic push(input int d, input int n);
    exp_t x;
    x.data = d;
    x.idx  = n;
    x.last = (n == NN - 1) ? 1 : 0;
    sb_q.push_back(x);
  endtask

  task automatic set_w_const(input int w);
    for (int a = 0; a < 64; a++)
      for (int p = 0; p < NP; p++) wrom[a][p*8 +: 8] = 8'(w);
  endtask

  // weight for neuron n is n-5 at every input position
  task automatic set_w_lane();
    for (int a = 0; a < 64; a++)
      for (int p = 0; p < NP; p++) wrom[a][p*8 +: 8] = 8'((a / IS) * NP + p - 5);
  endtask

  task automatic set_b_const(input int b);
    for (int gi = 0; gi < 4; gi++)
      for (int p = 0; p < NP; p++) brom[gi][p*32 +: 32] = 32'(b);
  endtask

  task automatic set_b_ramp();
    for (int gi = 0; gi < 4; gi++)
      for (int p = 0; p < NP; p++) brom[gi][p*32 +: 32] = 32'((gi * NP + p) * 256);
  endtask

  task automatic send_vector(input logic [15:0] v);
    for (int i = 0; i < IS; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = v;
    end
    @(posedge clk);
    #1;
    t0 = cyc;
    in_valid = 1'b0;
  endtask

  task automatic drain(input bit toggle, input bit garbage);
    first_valid = -1;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (toggle) out_ready = (i % 2 == 0);
      in_valid = garbage && (i < 12) && (i % 2 == 0);
      in_data  = 16'h7abc;
      #2;
      if (out_valid && first_valid < 0) first_valid = cyc - t0;
      if (sb_q.size() == 0) break;
    end
    check("drain_done", sb_q.size(), 0);
    sb_q.delete();
    @(negedge clk);
    out_ready = 1'b1;
    in_valid  = 1'b0;
    #2;
    check("post_in_ready", in_ready, 1);
    check("post_busy", busy, 0);
    check("post_out_valid", out_valid, 0);
  endtask

  // Scoreboard monitor: samples just after the falling edge
  always begin
    @(negedge clk);
    #1;
    if (!rst) begin
      if (out_valid) begin
        if (sb_q.size() == 0) begin
          check("unexpected_out_index", out_index, -1);
        end else begin
          check("out_data", out_data, sb_q[0].data);
          check("out_index", out_index, sb_q[0].idx);
          check("out_last", out_last, sb_q[0].last);
          if (out_ready) begin
            if (sb_q[0].last != 0) last_hs = cyc + 1;
            void'(sb_q.pop_front());
          end
        end
      end
      if (sb_q.size() > 0) check("in_ready_while_busy", in_ready, 0);
      if (addr_chk_en) begin
        ac = cyc - t0;
        for (int gi = 0; gi < 3; gi++) begin
          if (ac >= gi * (IS + 1 + NP) && ac < gi * (IS + 1 + NP) + IS) begin
            check("weight_addr", weight_addr, gi * IS + ac - gi * (IS + 1 + NP));
            check("bias_addr", bias_addr, gi);
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got cycle %0d, expected completion", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    in_valid = 1'b0;
    in_data = '0;
    out_ready = 1'b1;
    set_w_const(0);
    set_b_const(0);
    #1 rst = 1'b1;
    @(negedge clk);
    #1;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_last", out_last, 0);
    check("rst_out_index", out_index, 0);
    check("rst_out_data", out_data, 0);
    check("rst_busy", busy, 0);
    check("rst_weight_addr", weight_addr, 0);
    check("rst_bias_addr", bias_addr, 0);
    @(negedge clk);
    rst = 1'b0;

    // identity scale, latency and ROM address sequence
    set_w_const(1);
    set_b_const(0);
    send_vector(16'd256);
    for (int n = 0; n < NN; n++) push(16, n);
    last_hs = -1;
    addr_chk_en = 1'b1;
    drain(1'b0, 1'b0);
    addr_chk_en = 1'b0;
    check("first_valid_latency", first_valid, 17);
    check("last_handshake_latency", last_hs - t0, 61);

    // positive and negative saturation
    set_w_const(127);
    send_vector(16'd32767);
    for (int n = 0; n < NN; n++) push(32767, n);
    drain(1'b0, 1'b0);
    set_w_const(-128);
    send_vector(16'd32767);
    for (int n = 0; n < NN; n++) push(relu(-32768), n);
    drain(1'b0, 1'b0);

    // bias only: ramp, negative, and floor of a small negative
    set_w_const(1);
    set_b_ramp();
    send_vector(16'd0);
    for (int n = 0; n < NN; n++) push(n, n);
    drain(1'b0, 1'b0);
    set_b_const(-512);
    send_vector(16'd0);
    for (int n = 0; n < NN; n++) push(relu(-2), n);
    drain(1'b0, 1'b0);
    set_b_const(-1);
    send_vector(16'd0);
    for (int n = 0; n < NN; n++) push(relu(-1), n);
    drain(1'b0, 1'b0);

    // per-neuron weights n-5 with bias n*256: 16*(n-5)+n
    set_w_lane();
    set_b_ramp();
    send_vector(16'd256);
    for (int n = 0; n < NN; n++) push(relu(17 * n - 80), n);
    drain(1'b0, 1'b0);

    // backpressure plus ignored in_valid pulses while busy
    set_w_const(1);
    set_b_const(0);
    send_vector(16'd256);
    for (int n = 0; n < NN; n++) push(16, n);
    drain(1'b1, 1'b1);

    // reset during group 1 compute, then a clean vector
    send_vector(16'd256);
    for (int n = 0; n < NN; n++) push(16, n);
    for (int i = 0; i < 100 && (cyc - t0) < 25; i++) @(negedge clk);
    #3 rst = 1'b1;
    #1;
    sb_q.delete();
    check("midrst_out_valid", out_valid, 0);
    check("midrst_busy", busy, 0);
    check("midrst_in_ready", in_ready, 1);
    @(negedge clk);
    rst = 1'b0;
    send_vector(16'd256);
    for (int n = 0; n < NN; n++) push(16, n);
    drain(1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
